vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Raster timing generator for the TinyQV VGA peripheral. It sits directly upstream of the pixel/colour stage and produces the beam position (x, y), the sync pulses, a blanking flag and a sticky frame interrupt. All of these are registered and phase-aligned, so the downstream stage can index video memory and gate colour without any skew compensation. Defaults are 1024x768@60 (VESA, 65 MHz nominal), run from the 64 MHz project clock.

## Interface
Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, hsync pulse width (clocks)
- H_BP, 160, horizontal back porch (clocks)
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cli  in  1  clear interrupt (level, sampled every clk)
- line_cmp  in  10  line-interrupt compare value (present only with VGA_SYNC_GEN_LINE_IRQ_EN)
- x  out  11  horizontal position, 0..H_TOTAL-1
- y  out  10  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per H_POL
- vsync  out  1  vertical sync, polarity per V_POL
- blank  out  1  high outside the active area
- interrupt  out  1  sticky interrupt request

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1344; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 806. Both are unsigned and must fit in the port widths.
- x increments every clk. At H_TOTAL-1, x wraps to 0 and y increments. At the end of line V_TOTAL-1, y wraps to 0 (new frame).
- hsync is active for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync is active for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). vsync changes only at x = 0.
- blank = (x >= H_ACTIVE) | (y >= V_ACTIVE).
- Interrupt set event: (x, y) becomes (0, V_ACTIVE), i.e. the first clock of vertical blank.
- interrupt is sticky: it is set by a set event and cleared when cli is sampled high.
- If a set event and cli occur in the same cycle, set wins and interrupt stays high.
- Reset values: x = 0, y = 0, hsync = !H_POL, vsync = !V_POL, blank = 0, interrupt = 0.

## Timing
- All outputs are registered and update on the same clk edge.
- hsync, vsync and blank are decoded from the next-state counters. They therefore describe the x/y value presented in the same cycle: zero skew, zero latency relative to x/y.
- cli sampled high at edge N gives interrupt = 0 after edge N, unless a set event also occurs at N.
- rst_n low at any point, including mid-line or mid-sync, forces the reset values at the next edge. Counting resumes from (0,0) on the first edge with rst_n high.
- Frame period is H_TOTAL*V_TOTAL = 1,083,264 clocks.

## Configuration
- Macro: VGA_SYNC_GEN_LINE_IRQ_EN.
- Defined:
  - The line_cmp port exists.
  - An additional set event fires when (x, y) becomes (H_ACTIVE, line_cmp), i.e. the start of horizontal blank on that line.
  - line_cmp >= V_TOTAL never fires.
  - line_cmp is sampled in the cycle of the comparison.
  - Both sources set the same sticky interrupt.
- Undefined: no line_cmp port; only the vertical-blank set event exists.

## Structure
- Package vga_sync_pkg holds:
  - the default 1024x768 timing constants;
  - derived H_TOTAL and V_TOTAL;
  - the X_W = 11 and Y_W = 10 width constants.
- Sub-module vga_axis_counter is instantiated twice:
  - Horizontal instance: enable = 1.
  - Vertical instance: enable = horizontal wrap.
  - Each instance provides a parameterised modulo counter, next-value output, wrap flag and active/sync window decode.
- The top level holds only the interrupt register, the optional line compare and the output registers.

## Test plan
- Reset: hold rst_n low 4 clocks, release -> x=0, y=0, hsync=1, vsync=1, blank=0, interrupt=0.
- Line timing: run 2 lines ->
  - x wraps 1343->0 and y steps 0->1 on the same edge;
  - hsync is low exactly for x=1048..1183 (136 clocks);
  - blank is high exactly for x=1024..1343.
- Frame timing: run 1 frame ->
  - vsync is low for y=771..776, toggling only at x=0;
  - y wraps 805->0 after 1,083,264 clocks.
- Interrupt: interrupt rises with (x,y)=(0,768) and holds until a 1-clock cli pulse, then falls next edge. A cli pulse coincident with (0,768) leaves interrupt high.
- Reset mid-frame: drop rst_n at (500,300) during active video -> reset values on the next edge, then counting restarts from (0,0).
- Line IRQ (macro defined), line_cmp=100 -> interrupt rises at (1024,100) and again at (0,768). Same bench without the macro -> only (0,768).

Source files
------------

// File: rtl/vga_sync_pkg.sv
// vga_sync_pkg
// Shared timing constants for the VGA raster generator.
//   - DEF_* : 1024x768@60 timing (VESA, 65 MHz nominal)
//   - DEF_H_TOTAL / DEF_V_TOTAL : derived line and frame lengths
//   - X_W / Y_W : widths of the x and y position buses
package vga_sync_pkg;

    localparam int unsigned X_W = 11;
    localparam int unsigned Y_W = 10;

    localparam int unsigned DEF_H_ACTIVE = 1024;
    localparam int unsigned DEF_H_FP     = 24;
    localparam int unsigned DEF_H_SYNC   = 136;
    localparam int unsigned DEF_H_BP     = 160;

    localparam int unsigned DEF_V_ACTIVE = 768;
    localparam int unsigned DEF_V_FP     = 3;
    localparam int unsigned DEF_V_SYNC   = 6;
    localparam int unsigned DEF_V_BP     = 29;

    localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One axis of the raster: modulo-TOTAL counter plus window decode of the
// value it will hold after the next edge.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (count -> 0)
//   en           advance the count this cycle
//   cnt          registered count, 0..TOTAL-1
//   cnt_next     value cnt takes at the next edge
//   wrap         en is high and cnt is at TOTAL-1
//   in_active    cnt_next < ACTIVE
//   in_sync      cnt_next in [SYNC_START, SYNC_END)
module vga_axis_counter #(
    parameter int unsigned W          = 11,
    parameter int unsigned TOTAL      = 1344,
    parameter int unsigned ACTIVE     = 1024,
    parameter int unsigned SYNC_START = 1048,
    parameter int unsigned SYNC_END   = 1184
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_next,
    output logic         wrap,
    output logic         in_active,
    output logic         in_sync
);

    localparam logic [W-1:0] LAST   = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT    = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_S = W'(SYNC_START);
    localparam logic [W-1:0] SYNC_E = W'(SYNC_END);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        wrap  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (wrap) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Decoding the next value lets the caller register these flags
        // alongside the count with no skew.
        in_active = (cnt_d < ACT);
        in_sync   = (cnt_d >= SYNC_S) && (cnt_d < SYNC_E);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign cnt_next = cnt_d;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// Raster timing generator: beam position, sync pulses, blanking flag and a
// sticky frame interrupt, all registered on the same edge.
// Optional feature macro: VGA_SYNC_GEN_LINE_IRQ_EN adds the line_cmp input
// and a second interrupt source at the start of horizontal blank on line
// line_cmp.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   cli         clear interrupt (level, sampled every clock)
//   line_cmp    line-interrupt compare value (only with the macro)
//   x, y        beam position
//   hsync       horizontal sync, active level H_POL
//   vsync       vertical sync, active level V_POL
//   blank       high outside the active area
//   interrupt   sticky interrupt request
module vga_sync_gen
    import vga_sync_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cli,
`ifdef VGA_SYNC_GEN_LINE_IRQ_EN
    input  logic [Y_W-1:0] line_cmp,
`endif
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           hsync,
    output logic           vsync,
    output logic           blank,
    output logic           interrupt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [X_W-1:0] x_next;
    logic [Y_W-1:0] y_next;
    logic           h_wrap;
    logic           h_active, v_active;
    logic           h_sync_win, v_sync_win;
    logic           v_wrap_unused;
    logic           irq_set;

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic blank_q, blank_d;
    logic interrupt_q, interrupt_d;

    vga_axis_counter #(
        .W          (X_W),
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
    ) u_h_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (1'b1),
        .cnt       (x),
        .cnt_next  (x_next),
        .wrap      (h_wrap),
        .in_active (h_active),
        .in_sync   (h_sync_win)
    );

    // Advancing y only on the horizontal wrap keeps vsync changes at x = 0.
    vga_axis_counter #(
        .W          (Y_W),
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
    ) u_v_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (h_wrap),
        .cnt       (y),
        .cnt_next  (y_next),
        .wrap      (v_wrap_unused),
        .in_active (v_active),
        .in_sync   (v_sync_win)
    );

    always_comb begin
        hsync_d = h_sync_win ? H_POL : ~H_POL;
        vsync_d = v_sync_win ? V_POL : ~V_POL;
        blank_d = ~(h_active & v_active);

        // Set event: the position about to be presented is (0, V_ACTIVE).
        irq_set = (x_next == '0) && (y_next == Y_W'(V_ACTIVE));
`ifdef VGA_SYNC_GEN_LINE_IRQ_EN
        // y_next never reaches V_TOTAL, so out-of-range compares never fire.
        irq_set = irq_set || ((x_next == X_W'(H_ACTIVE)) && (y_next == line_cmp));
`endif
        // Set has priority over a coincident clear.
        interrupt_d = irq_set | (interrupt_q & ~cli);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_q     <= ~H_POL;
            vsync_q     <= ~V_POL;
            blank_q     <= 1'b0;
            interrupt_q <= 1'b0;
        end else begin
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            blank_q     <= blank_d;
            interrupt_q <= interrupt_d;
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign blank     = blank_q;
    assign interrupt = interrupt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
// Drives two generators from one clock/reset/cli: a reduced-timing instance
// (short frames, inverted hsync polarity) and a default 1024x768 instance.
module tb_vga_sync_gen;

    // Reduced timing: H 20/4/6/6 (total 36), V 12/2/3/3 (total 20).
    localparam int S_HA = 20, S_HF = 4, S_HS = 6, S_HB = 6;
    localparam int S_VA = 12, S_VF = 2, S_VS = 3, S_VB = 3;
    localparam int S_HT = 36, S_VT = 20;

`ifdef VGA_SYNC_GEN_LINE_IRQ_EN
    localparam bit LINE_EN = 1'b1;
`else
    localparam bit LINE_EN = 1'b0;
`endif
    localparam int LC_S = 5;
    localparam int LC_D = 100;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        irq;
    } obs_t;

    typedef struct {
        int ht, vt, ha, hss, hse, va, vss, vse;
        bit hp, vp;
    } tim_t;

    typedef struct {
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic bl;
    } spot_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cli = 1'b0;
    always #5 clk = ~clk;

`ifdef VGA_SYNC_GEN_LINE_IRQ_EN
    logic [9:0] lcmp_s = 10'(LC_S);
    logic [9:0] lcmp_d = 10'(LC_D);
`endif

    logic [10:0] s_x, d_x;
    logic [9:0]  s_y, d_y;
    logic        s_hs, s_vs, s_bl, s_irq;
    logic        d_hs, d_vs, d_bl, d_irq;

    vga_sync_gen #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
        .H_POL    (1'b1), .V_POL (1'b0)
    ) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .cli       (cli),
`ifdef VGA_SYNC_GEN_LINE_IRQ_EN
        .line_cmp  (lcmp_s),
`endif
        .x         (s_x),
        .y         (s_y),
        .hsync     (s_hs),
        .vsync     (s_vs),
        .blank     (s_bl),
        .interrupt (s_irq)
    );

    vga_sync_gen dut_d (
        .clk       (clk),
        .rst_n     (rst_n),
        .cli       (cli),
`ifdef VGA_SYNC_GEN_LINE_IRQ_EN
        .line_cmp  (lcmp_d),
`endif
        .x         (d_x),
        .y         (d_y),
        .hsync     (d_hs),
        .vsync     (d_vs),
        .blank     (d_bl),
        .interrupt (d_irq)
    );

    // ---------------- scoreboard ----------------
    logic [24:0] s_exp_q[$];
    logic [24:0] d_exp_q[$];
    int n_pass = 0;
    int n_total = 0;

    tim_t tim_s, tim_d;
    int sm_x = 0, sm_y = 0, dm_x = 0, dm_y = 0;
    logic sm_irq = 1'b0, dm_irq = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: advance a position by one clock and describe it from the
    // position itself.
    function automatic obs_t model_next(input tim_t t, input int cx, input int cy,
                                        input logic rst, input logic clr,
                                        input logic irq, input int lc);
        obs_t o;
        int nx, ny;
        bit set;
        if (rst !== 1'b1) begin
            o.x = '0; o.y = '0; o.hs = !t.hp; o.vs = !t.vp; o.bl = 1'b0; o.irq = 1'b0;
            return o;
        end
        nx = (cx == t.ht - 1) ? 0 : cx + 1;
        ny = (cx == t.ht - 1) ? ((cy == t.vt - 1) ? 0 : cy + 1) : cy;
        set = (nx == 0 && ny == t.va) || (LINE_EN && nx == t.ha && ny == lc);
        o.x   = nx[10:0];
        o.y   = ny[9:0];
        o.hs  = (nx >= t.hss && nx < t.hse) ? t.hp : !t.hp;
        o.vs  = (ny >= t.vss && ny < t.vse) ? t.vp : !t.vp;
        o.bl  = (nx >= t.ha) || (ny >= t.va);
        o.irq = set || (irq && !clr);
        return o;
    endfunction

    task automatic compare_one(input string tag, input obs_t e, input logic [10:0] ax,
                               input logic [9:0] ay, input logic ahs, input logic avs,
                               input logic abl, input logic airq);
        check({tag, "_x"}, ax, e.x);
        check({tag, "_y"}, ay, e.y);
        check({tag, "_hsync"}, ahs, e.hs);
        check({tag, "_vsync"}, avs, e.vs);
        check({tag, "_blank"}, abl, e.bl);
        check({tag, "_irq"}, airq, e.irq);
    endtask

    // One clock: predict both instances from the inputs now driven, then
    // compare just after the edge.
    task automatic step();
        obs_t e;
        e = model_next(tim_s, sm_x, sm_y, rst_n, cli, sm_irq, LC_S);
        s_exp_q.push_back(e);
        sm_x = int'(e.x); sm_y = int'(e.y); sm_irq = e.irq;
        e = model_next(tim_d, dm_x, dm_y, rst_n, cli, dm_irq, LC_D);
        d_exp_q.push_back(e);
        dm_x = int'(e.x); dm_y = int'(e.y); dm_irq = e.irq;
        @(posedge clk);
        #1;
        e = s_exp_q.pop_front();
        compare_one("s", e, s_x, s_y, s_hs, s_vs, s_bl, s_irq);
        e = d_exp_q.pop_front();
        compare_one("d", e, d_x, d_y, d_hs, d_vs, d_bl, d_irq);
    endtask

    task automatic run_until_s(input int tx, input int ty);
        for (int n = 0; n < 1000 && !(sm_x == tx && sm_y == ty); n++) step();
    endtask

    task automatic run_until_d(input int tx, input int ty);
        for (int n = 0; n < 3000 && !(dm_x == tx && dm_y == ty); n++) step();
    endtask

    task automatic pulse_cli();
        cli = 1'b1;
        step();
        cli = 1'b0;
    endtask

    spot_t spots[10];

    initial begin
        tim_s = '{S_HT, S_VT, S_HA, S_HA + S_HF, S_HA + S_HF + S_HS,
                  S_VA, S_VA + S_VF, S_VA + S_VF + S_VS, 1'b1, 1'b0};
        tim_d = '{1344, 806, 1024, 1048, 1184, 768, 771, 777, 1'b0, 1'b0};

        // Default-timing spot vectors: {x, y, hsync, vsync, blank}.
        spots[0] = '{1023, 0, 1'b1, 1'b1, 1'b0};
        spots[1] = '{1024, 0, 1'b1, 1'b1, 1'b1};
        spots[2] = '{1047, 0, 1'b1, 1'b1, 1'b1};
        spots[3] = '{1048, 0, 1'b0, 1'b1, 1'b1};
        spots[4] = '{1183, 0, 1'b0, 1'b1, 1'b1};
        spots[5] = '{1184, 0, 1'b1, 1'b1, 1'b1};
        spots[6] = '{1343, 0, 1'b1, 1'b1, 1'b1};
        spots[7] = '{0,    1, 1'b1, 1'b1, 1'b0};
        spots[8] = '{1048, 1, 1'b0, 1'b1, 1'b1};
        spots[9] = '{1343, 1, 1'b1, 1'b1, 1'b1};

        // Reset held for 4 clocks.
        rst_n = 1'b0;
        repeat (4) step();
        check("rst_d_x", d_x, 0);
        check("rst_d_y", d_y, 0);
        check("rst_d_hsync", d_hs, 1);
        check("rst_d_vsync", d_vs, 1);
        check("rst_d_blank", d_bl, 0);
        check("rst_d_irq", d_irq, 0);
        check("rst_s_hsync", s_hs, 0);
        check("rst_s_vsync", s_vs, 1);
        rst_n = 1'b1;

        // Line timing at default parameters, two lines.
        for (int i = 0; i < 10; i++) begin
            run_until_d(spots[i].x, spots[i].y);
            check($sformatf("spot%0d_x", i), d_x, spots[i].x);
            check($sformatf("spot%0d_y", i), d_y, spots[i].y);
            check($sformatf("spot%0d_hsync", i), d_hs, spots[i].hs);
            check($sformatf("spot%0d_vsync", i), d_vs, spots[i].vs);
            check($sformatf("spot%0d_blank", i), d_bl, spots[i].bl);
        end

        // Interrupt: rise at (0, V_ACTIVE), hold, clear with cli.
        run_until_s(5, 3);
        pulse_cli();
        check("irq_clear0", s_irq, 0);
        run_until_s(0, S_VA);
        check("irq_rise", s_irq, 1);
        repeat (3) step();
        check("irq_hold", s_irq, 1);
        pulse_cli();
        check("irq_fall", s_irq, 0);
        step();
        check("irq_stay_low", s_irq, 0);
        // cli coincident with the set event: set wins.
        run_until_s(S_HT - 1, S_VA - 1);
        pulse_cli();
        check("irq_set_wins", s_irq, 1);
        check("irq_set_wins_x", s_x, 0);
        check("irq_set_wins_y", s_y, S_VA);

        // Line interrupt at (H_ACTIVE, line_cmp) only when the feature is built.
        run_until_s(5, 2);
        pulse_cli();
        check("line_irq_pre", s_irq, 0);
        run_until_s(S_HA - 1, LC_S);
        step();
        check("line_irq_x", s_x, S_HA);
        check("line_irq_y", s_y, LC_S);
        check("line_irq", s_irq, LINE_EN);

        // vsync edges at x = 0 of lines 14 and 17.
        run_until_s(S_HT - 1, 13);
        check("vs_before", s_vs, 1);
        step();
        check("vs_start", s_vs, 0);
        check("vs_start_x", s_x, 0);
        run_until_s(S_HT - 1, 16);
        check("vs_last", s_vs, 0);
        step();
        check("vs_end", s_vs, 1);
        check("vs_end_y", s_y, 17);

        // Frame period: back to (0,0) after exactly S_HT*S_VT clocks.
        run_until_s(0, 0);
        repeat (S_HT * S_VT - 1) step();
        check("frame_last_x", s_x, S_HT - 1);
        check("frame_last_y", s_y, S_VT - 1);
        step();
        check("frame_wrap_x", s_x, 0);
        check("frame_wrap_y", s_y, 0);
        run_until_s(24, 0);
        check("hs_s_start", s_hs, 1);
        run_until_s(30, 0);
        check("hs_s_end", s_hs, 0);

        // Reset mid active video, then mid hsync/vsync.
        run_until_s(10, 5);
        rst_n = 1'b0;
        step();
        check("mrst_x", s_x, 0);
        check("mrst_y", s_y, 0);
        check("mrst_hsync", s_hs, 0);
        check("mrst_vsync", s_vs, 1);
        check("mrst_blank", s_bl, 0);
        check("mrst_irq", s_irq, 0);
        rst_n = 1'b1;
        step();
        check("mrst_resume_x", s_x, 1);
        check("mrst_resume_y", s_y, 0);
        run_until_s(25, 15);
        rst_n = 1'b0;
        step();
        check("srst_hsync", s_hs, 0);
        check("srst_vsync", s_vs, 1);
        check("srst_x", s_x, 0);
        rst_n = 1'b1;
        repeat (3) step();

        check("queue_s_empty", s_exp_q.size(), 0);
        check("queue_d_empty", d_exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
